// File: rtl/router_fsm_nch_if.sv
// Router control bundle between the register/parity block, synchroniser and
// the router control FSM.
//   slave  : FSM side (consumes packet/FIFO status, produces state decodes)
//   master : environment side (drives packet/FIFO status, observes decodes)
interface router_fsm_nch_if #(
   parameter int unsigned NUM_CH = 3,
   parameter int unsigned ADDR_W = 2
);
   logic              pkt_valid;
   logic [ADDR_W-1:0] data_in;
   logic              fifo_full;
   logic [NUM_CH-1:0] fifo_empty;
   logic [NUM_CH-1:0] soft_reset;
   logic              parity_done;
   logic              low_pkt_valid;

   logic              detect_add;
   logic              lfd_state;
   logic              ld_state;
   logic              laf_state;
   logic              full_state;
   logic              write_enb_reg;
   logic              rst_int_reg;
   logic              busy;
   logic              drop_pkt;
   logic [ADDR_W-1:0] addr_q;
   logic              addr_err;
   logic              wte_timeout;

   modport slave (
      input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
             parity_done, low_pkt_valid,
      output detect_add, lfd_state, ld_state, laf_state, full_state,
             write_enb_reg, rst_int_reg, busy, drop_pkt, addr_q,
             addr_err, wte_timeout
   );

   modport master (
      output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
             parity_done, low_pkt_valid,
      input  detect_add, lfd_state, ld_state, laf_state, full_state,
             write_enb_reg, rst_int_reg, busy, drop_pkt, addr_q,
             addr_err, wte_timeout
   );
endinterface

// File: rtl/router_fsm_nch.sv
// Packet-router control FSM for NUM_CH output channels. Decodes the header
// address, sequences header/payload/parity loads into the selected FIFO,
// stalls on FIFO full, and drops packets with an illegal address or that
// wait too long for a busy destination.
//   clock  : rising-edge clock
//   resetn : synchronous active-low reset
//   bus    : slave side of router_fsm_nch_if (status in, state decodes out)
module router_fsm_nch #(
   parameter int unsigned NUM_CH      = 3,
   parameter int unsigned ADDR_W      = 2,
   parameter int unsigned WTE_TIMEOUT = 255
) (
   input  logic            clock,
   input  logic            resetn,
   router_fsm_nch_if.slave bus
);

   localparam int unsigned NSEL  = 1 << ADDR_W;
   localparam int unsigned CNT_W = 16;
   localparam logic [ADDR_W:0]  CH_LIMIT   = (ADDR_W+1)'(NUM_CH);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WTE_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic             TIMEOUT_EN = (WTE_TIMEOUT != 0);

   typedef enum logic [3:0] {
      DA   = 4'd0,
      LFD  = 4'd1,
      LD   = 4'd2,
      WTE  = 4'd3,
      CPE  = 4'd4,
      LP   = 4'd5,
      FFS  = 4'd6,
      LAF  = 4'd7,
      DROP = 4'd8
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_r, addr_nxt;
   logic [CNT_W-1:0]  cnt_r, cnt_nxt;
   logic              addr_err_nxt, wte_to_nxt;
   logic              addr_err_r, wte_to_r;
   logic [8:0]        dec_r, dec_nxt;

   // Pad per-channel flags to the full address space; unused codes read 0.
   logic [NSEL-1:0]   empty_pad, soft_pad;
   assign empty_pad = NSEL'(bus.fifo_empty);
   assign soft_pad  = NSEL'(bus.soft_reset);

   // State register plus registered outputs (decoded from next state).
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state      <= DA;
         addr_r     <= '0;
         cnt_r      <= '0;
         addr_err_r <= 1'b0;
         wte_to_r   <= 1'b0;
         dec_r      <= 9'b1_0000_0000;
      end else begin
         state      <= state_nxt;
         addr_r     <= addr_nxt;
         cnt_r      <= cnt_nxt;
         addr_err_r <= addr_err_nxt;
         wte_to_r   <= wte_to_nxt;
         dec_r      <= dec_nxt;
      end
   end

   // Next-state, address latch, wait counter and drop pulses.
   always_comb begin
      state_nxt    = state;
      addr_nxt     = addr_r;
      cnt_nxt      = '0;
      addr_err_nxt = 1'b0;
      wte_to_nxt   = 1'b0;
      if (state != DA && soft_pad[addr_r]) begin
         state_nxt = DA;
      end else begin
         unique case (state)
            DA: begin
               if (bus.pkt_valid) begin
                  addr_nxt = bus.data_in;
                  if ({1'b0, bus.data_in} >= CH_LIMIT) begin
                     state_nxt    = DROP;
                     addr_err_nxt = 1'b1;
                  end else if (empty_pad[bus.data_in]) begin
                     state_nxt = LFD;
                  end else begin
                     state_nxt = WTE;
                  end
               end
            end
            LFD: state_nxt = LD;
            LD: begin
               if (bus.fifo_full)       state_nxt = FFS;
               else if (!bus.pkt_valid) state_nxt = LP;
            end
            FFS: if (!bus.fifo_full) state_nxt = LAF;
            LAF: begin
               if (bus.parity_done)        state_nxt = DA;
               else if (bus.low_pkt_valid) state_nxt = LP;
               else                        state_nxt = LD;
            end
            LP:  state_nxt = CPE;
            CPE: state_nxt = bus.fifo_full ? FFS : DA;
            WTE: begin
               // A FIFO draining on the expiry cycle still wins over the drop.
               if (empty_pad[addr_r]) begin
                  state_nxt = LFD;
               end else if (TIMEOUT_EN && cnt_r == CNT_LAST) begin
                  state_nxt  = DROP;
                  wte_to_nxt = 1'b1;
               end else begin
                  cnt_nxt = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + 1'b1;
               end
            end
            DROP: if (!bus.pkt_valid) state_nxt = DA;
            default: state_nxt = DA;
         endcase
      end
   end

   // Moore decodes, bit order: da lfd ld laf ffs wen rst_int busy drop.
   always_comb begin
      dec_nxt = '0;
      unique case (state_nxt)
         DA:      dec_nxt = 9'b1_0000_0000;
         LFD:     dec_nxt = 9'b0_1000_0010;
         LD:      dec_nxt = 9'b0_0100_1000;
         LAF:     dec_nxt = 9'b0_0010_1010;
         FFS:     dec_nxt = 9'b0_0001_0010;
         LP:      dec_nxt = 9'b0_0000_1010;
         CPE:     dec_nxt = 9'b0_0000_0110;
         WTE:     dec_nxt = 9'b0_0000_0010;
         DROP:    dec_nxt = 9'b0_0000_0001;
         default: dec_nxt = 9'b1_0000_0000;
      endcase
   end

   assign bus.detect_add    = dec_r[8];
   assign bus.lfd_state     = dec_r[7];
   assign bus.ld_state      = dec_r[6];
   assign bus.laf_state     = dec_r[5];
   assign bus.full_state    = dec_r[4];
   assign bus.write_enb_reg = dec_r[3];
   assign bus.rst_int_reg   = dec_r[2];
   assign bus.busy          = dec_r[1];
   assign bus.drop_pkt      = dec_r[0];
   assign bus.addr_q        = addr_r;
   assign bus.addr_err      = addr_err_r;
   assign bus.wte_timeout   = wte_to_r;

endmodule

// File: tb/tb_router_fsm_nch.sv
// Directed bench for router_fsm_nch (NUM_CH=3, ADDR_W=2, WTE_TIMEOUT=5).
// Output vector order: da lfd ld laf ffs wen rst_int busy drop addr_err wte_to.
module tb_router_fsm_nch;

   localparam logic [10:0] E_DA   = 11'b100_0000_0000;
   localparam logic [10:0] E_LFD  = 11'b010_0000_1000;
   localparam logic [10:0] E_LD   = 11'b001_0010_0000;
   localparam logic [10:0] E_LAF  = 11'b000_1010_1000;
   localparam logic [10:0] E_FFS  = 11'b000_0100_1000;
   localparam logic [10:0] E_LP   = 11'b000_0010_1000;
   localparam logic [10:0] E_CPE  = 11'b000_0001_1000;
   localparam logic [10:0] E_WTE  = 11'b000_0000_1000;
   localparam logic [10:0] E_DROP = 11'b000_0000_0100;
   localparam logic [10:0] E_DRAE = 11'b000_0000_0110;
   localparam logic [10:0] E_DRTO = 11'b000_0000_0101;

   logic clock;
   logic resetn;
   int   n_cmp;
   int   n_err;

   router_fsm_nch_if #(.NUM_CH(3), .ADDR_W(2)) bus ();

   router_fsm_nch #(.NUM_CH(3), .ADDR_W(2), .WTE_TIMEOUT(5)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   function automatic logic [10:0] outs();
      return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
              bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy,
              bus.drop_pkt, bus.addr_err, bus.wte_timeout};
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic step(input string tag, input logic [10:0] exp);
      tick();
      check_val(tag, 32'(outs()), 32'(exp));
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      clock = 1'b0;
      resetn = 1'b0;
      bus.pkt_valid = 1'b0;
      bus.data_in = '0;
      bus.fifo_full = 1'b0;
      bus.fifo_empty = '0;
      bus.soft_reset = '0;
      bus.parity_done = 1'b0;
      bus.low_pkt_valid = 1'b0;

      step("rst_outs", E_DA);
      check_val("rst_addr", 32'(bus.addr_q), 32'd0);
      resetn = 1'b1;

      // Short packet to channel 2
      bus.pkt_valid = 1'b1; bus.data_in = 2'd2; bus.fifo_empty = 3'b100;
      step("t1_lfd", E_LFD);
      check_val("t1_addr", 32'(bus.addr_q), 32'd2);
      step("t1_ld0", E_LD);
      step("t1_ld1", E_LD);
      bus.pkt_valid = 1'b0;
      step("t1_lp", E_LP);
      step("t1_cpe", E_CPE);
      step("t1_da", E_DA);

      // Full stall, then low_pkt_valid exit
      bus.pkt_valid = 1'b1; bus.data_in = 2'd0; bus.fifo_empty = 3'b001;
      step("t2_lfd", E_LFD);
      step("t2_ld", E_LD);
      bus.fifo_full = 1'b1;
      for (int i = 0; i < 4; i++) step($sformatf("t2_ffs%0d", i), E_FFS);
      bus.fifo_full = 1'b0; bus.low_pkt_valid = 1'b1;
      step("t2_laf", E_LAF);
      step("t2_lp", E_LP);
      bus.low_pkt_valid = 1'b0; bus.pkt_valid = 1'b0;
      step("t2_cpe", E_CPE);
      step("t2_da", E_DA);

      // LAF back to LD, then LAF exit on parity_done
      bus.pkt_valid = 1'b1;
      step("t2b_lfd", E_LFD);
      step("t2b_ld", E_LD);
      bus.fifo_full = 1'b1;
      step("t2b_ffs", E_FFS);
      bus.fifo_full = 1'b0;
      step("t2b_laf", E_LAF);
      step("t2b_ld2", E_LD);
      bus.fifo_full = 1'b1;
      step("t2b_ffs2", E_FFS);
      bus.fifo_full = 1'b0;
      step("t2b_laf2", E_LAF);
      bus.parity_done = 1'b1;
      step("t2b_da", E_DA);
      bus.parity_done = 1'b0; bus.pkt_valid = 1'b0;
      step("t2b_idle", E_DA);

      // Illegal address
      bus.pkt_valid = 1'b1; bus.data_in = 2'd3;
      step("t3_drop_ae", E_DRAE);
      check_val("t3_addr", 32'(bus.addr_q), 32'd3);
      step("t3_drop", E_DROP);
      bus.pkt_valid = 1'b0;
      step("t3_da", E_DA);

      // Wait-till-empty timeout
      bus.pkt_valid = 1'b1; bus.data_in = 2'd1; bus.fifo_empty = 3'b000;
      step("t4_wte0", E_WTE);
      for (int i = 1; i < 5; i++) step($sformatf("t4_wte%0d", i), E_WTE);
      step("t4_drop_to", E_DRTO);
      step("t4_drop", E_DROP);
      bus.pkt_valid = 1'b0;
      step("t4_da", E_DA);

      // FIFO drains on the expiry cycle: LFD wins
      bus.pkt_valid = 1'b1;
      step("t4b_wte0", E_WTE);
      for (int i = 1; i < 5; i++) step($sformatf("t4b_wte%0d", i), E_WTE);
      bus.fifo_empty = 3'b010;
      step("t4b_lfd", E_LFD);
      step("t4b_ld", E_LD);
      bus.pkt_valid = 1'b0;
      step("t4b_lp", E_LP);
      step("t4b_cpe", E_CPE);
      step("t4b_da", E_DA);

      // Soft reset: other channel ignored, selected channel wins over full
      bus.pkt_valid = 1'b1; bus.data_in = 2'd2; bus.fifo_empty = 3'b100;
      step("t5_lfd", E_LFD);
      step("t5_ld", E_LD);
      bus.soft_reset = 3'b001;
      step("t5_other", E_LD);
      bus.soft_reset = 3'b100;
      step("t5_sr_ld", E_DA);
      bus.soft_reset = 3'b000;
      step("t5_lfd2", E_LFD);
      step("t5_ld2", E_LD);
      bus.fifo_full = 1'b1;
      step("t5_ffs", E_FFS);
      bus.soft_reset = 3'b100;
      step("t5_sr_ffs", E_DA);
      bus.soft_reset = 3'b000; bus.fifo_full = 1'b0; bus.pkt_valid = 1'b0;
      step("t5_idle", E_DA);

      // Reset glitch between edges, then sync reset in LAF
      bus.pkt_valid = 1'b1;
      step("t6_lfd", E_LFD);
      step("t6_ld", E_LD);
      resetn = 1'b0;
      #3;
      resetn = 1'b1;
      step("t6_glitch", E_LD);
      check_val("t6_glitch_addr", 32'(bus.addr_q), 32'd2);
      bus.fifo_full = 1'b1;
      step("t6_ffs", E_FFS);
      bus.fifo_full = 1'b0;
      step("t6_laf", E_LAF);
      resetn = 1'b0;
      step("t6_rst", E_DA);
      check_val("t6_rst_addr", 32'(bus.addr_q), 32'd0);
      resetn = 1'b1; bus.pkt_valid = 1'b0;
      step("t6_idle", E_DA);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/router_fsm_nch.md
# router_fsm_nch

Parametrised packet-router control FSM: the next generation of the 1x3 router controller, generalised to NUM_CH output channels. It decodes the header address, sequences header/payload/parity loading into the destination FIFO, and stalls on FIFO full. It adds two behaviours: packets addressed to an illegal channel are dropped, and packets that wait too long for a busy destination are dropped. It sits between the register/parity block and the synchroniser of the router top.

## Interface
- NUM_CH, 3: number of output channels (2..2^ADDR_W).
- ADDR_W, 2: header address width; must satisfy 2^ADDR_W >= NUM_CH.
- WTE_TIMEOUT, 255: cycles allowed in WAIT_TILL_EMPTY before drop (0 = never time out; max 65535).

Ports:
- clock  in  1  single clock, rising edge.
- resetn  in  1  reset, synchronous, active-low.
- pkt_valid  in  1  source byte valid / packet in progress.
- data_in  in  ADDR_W  header address field (data_in[ADDR_W-1:0] of header byte).
- fifo_full  in  1  full flag of the currently selected FIFO.
- fifo_empty  in  NUM_CH  per-channel FIFO empty flags.
- soft_reset  in  NUM_CH  per-channel soft reset from synchroniser.
- parity_done  in  1  parity byte latched by register block.
- low_pkt_valid  in  1  pkt_valid fell while FIFO was full.
- detect_add, lfd_state, ld_state, laf_state, full_state  out  1 each  state decodes.
- write_enb_reg  out  1  write enable to register block.
- rst_int_reg  out  1  clear internal parity registers.
- busy  out  1  source must hold its current byte.
- drop_pkt  out  1  packet being discarded; no FIFO writes.
- addr_q  out  ADDR_W  latched destination address.
- addr_err  out  1  one-cycle pulse: illegal address detected.
- wte_timeout  out  1  one-cycle pulse: wait-till-empty timeout.

## Operation
- States (4-bit encoding): DA, LFD, LD, WTE, CPE, LP, FFS, LAF, DROP.
- Transition priority: resetn low > soft_reset[addr_q] (any state except DA -> DA) > the normal transitions below.
- DA: no action if pkt_valid=0. If pkt_valid=1, latch addr_q <= data_in. Then: data_in >= NUM_CH -> DROP with addr_err pulse; fifo_empty[data_in]=1 -> LFD; otherwise -> WTE with the counter cleared.
- LFD -> LD unconditionally.
- LD: fifo_full -> FFS; else pkt_valid=0 -> LP; else stay.
- FFS: fifo_full=0 -> LAF; else stay.
- LAF: parity_done -> DA; else low_pkt_valid -> LP; else LD.
- LP -> CPE unconditionally.
- CPE: fifo_full -> FFS; else DA.
- WTE: fifo_empty[addr_q] -> LFD. Otherwise, if WTE_TIMEOUT != 0 and the counter reaches WTE_TIMEOUT-1 -> DROP with wte_timeout pulse. Otherwise increment the counter.
- DROP: pkt_valid=0 -> DA; else stay.
- Outputs are Moore decodes of the current state:
  - detect_add = DA; lfd_state = LFD; ld_state = LD; laf_state = LAF; full_state = FFS.
  - write_enb_reg = LD | LP | LAF.
  - rst_int_reg = CPE.
  - busy = LFD | LP | FFS | LAF | CPE | WTE.
  - drop_pkt = DROP.
- addr_err and wte_timeout are registered. Each is high exactly the one cycle after the transition into DROP.
- Counter is 16 bits and saturates. It is cleared in every state except WTE.

## Timing
- Reset (resetn=0 at a clock edge) forces:
  - state = DA, addr_q = 0, counter = 0, addr_err = 0, wte_timeout = 0.
  - Resulting outputs: detect_add = 1, all other outputs 0.
- Reset mid-packet returns to DA on the next edge; no partial output persists.
- All transitions take one clock. Header accepted in DA gives LFD on the next cycle and first payload write enable (LD) one cycle after that.
- A soft_reset on a non-selected channel has no effect.
- Soft reset and fifo_full asserted together: soft reset wins.
- WTE with timeout: exactly WTE_TIMEOUT cycles are spent in WTE before DROP.
- fifo_empty rising in the same cycle the counter expires: LFD wins.

## Test plan
- Short packet, NUM_CH=3: header addr 2 with fifo_empty=3'b100, pkt_valid high 3 cycles -> DA, LFD, LD, LD, LP, CPE, DA. write_enb_reg is high in LD/LP, rst_int_reg high in CPE, addr_q=2.
- Full stall: fifo_full=1 during LD for 4 cycles -> FFS held 4 cycles with busy=1. Then fifo_full=0, parity_done=0, low_pkt_valid=1 -> LAF, LP, CPE, DA.
- Illegal address: NUM_CH=3, header addr 3 -> DROP with addr_err high for 1 cycle and write_enb_reg=0 throughout. pkt_valid low -> DA.
- WTE timeout: WTE_TIMEOUT=5, fifo_empty[1]=0, header addr 1 -> 5 cycles in WTE, then DROP with wte_timeout pulse. Repeat with fifo_empty[1] rising on cycle 5 -> LFD, no pulse.
- Soft reset: soft_reset[addr_q]=1 while in LD and FFS -> DA on next edge. soft_reset on another channel -> no effect.
- Sync reset mid-packet: resetn=0 for one edge while in LAF -> DA, addr_q=0, busy=0. Also check that resetn changing away from a clock edge has no effect.
